// File: rtl/dla_platform_csr_axi_initiator.sv
// AXI4-Lite CSR initiator: one command in, one AXI read/write out,
// one response back, with a timeout that never breaks the AXI handshake.
module dla_reset_handler_simple #(
    parameter int USE_SYNCHRONIZER = 1,
    parameter int PIPE_DEPTH       = 3
) (
    input  logic clk,
    input  logic i_resetn,
    output logic o_sclrn
);
    generate
        if (USE_SYNCHRONIZER != 0) begin : g_sync
            logic [PIPE_DEPTH-1:0] sync_q;
            always_ff @(posedge clk or negedge i_resetn) begin
                if (!i_resetn) sync_q <= '0;
                else           sync_q <= {sync_q[PIPE_DEPTH-2:0], 1'b1};
            end
            assign o_sclrn = sync_q[PIPE_DEPTH-1];
        end else begin : g_bypass
            assign o_sclrn = i_resetn;
        end
    endgenerate
endmodule

module dla_platform_csr_axi_initiator #(
    parameter int CSR_ADDR_WIDTH = 11,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        i_resetn_async,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_write,
    input  logic [CSR_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [CSR_DATA_WIDTH-1:0]   i_cmd_wdata,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [CSR_DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                        o_rsp_error,
    output logic                        o_rsp_timeout,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [CSR_ADDR_WIDTH-1:0]   o_awaddr,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [CSR_DATA_WIDTH-1:0]   o_wdata,
    output logic [CSR_DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [CSR_ADDR_WIDTH-1:0]   o_araddr,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [CSR_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                  i_rresp
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW:0] TO_VAL = (TW+1)'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RR, DONE} state_t;

    logic sclrn;

    dla_reset_handler_simple #(
        .USE_SYNCHRONIZER (1)
    ) u_rst (
        .clk      (clk),
        .i_resetn (i_resetn_async),
        .o_sclrn  (sclrn)
    );

    state_t                    state_q, state_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CSR_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [CSR_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_error_q, rsp_error_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      timed_out_q, timed_out_d;

    logic          b_hs, r_hs, rsp_hs, busy, timeout_hit;
    logic [TW:0]   timer_inc;
    logic          unused_resp;

    assign unused_resp = &{1'b0, i_bresp[0], i_rresp[0]};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q & ~i_awready;
        wvalid_d      = wvalid_q & ~i_wready;
        arvalid_d     = arvalid_q & ~i_arready;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_d       = timer_q;
        timed_out_d   = timed_out_q;

        b_hs      = bready_q & i_bvalid;
        r_hs      = rready_q & i_rvalid;
        rsp_hs    = rsp_valid_q & i_rsp_ready;
        busy      = (state_q == WR) || (state_q == WB) ||
                    (state_q == RA) || (state_q == RR);
        timer_inc = {1'b0, timer_q} + {{TW{1'b0}}, 1'b1};

        if (busy && !timed_out_q) timer_d = timer_inc[TW-1:0];

        if (rsp_hs) begin
            rsp_valid_d   = 1'b0;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b0;
            rsp_timeout_d = 1'b0;
        end

        // A completing B/R handshake in the expiry cycle takes priority.
        timeout_hit = TO_EN && busy && !timed_out_q &&
                      (timer_inc == TO_VAL) && !b_hs && !r_hs;
        if (timeout_hit) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b0;
            rsp_timeout_d = 1'b1;
            timed_out_d   = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                    if (i_cmd_write) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RA;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end
            end
            WB: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (!timed_out_q) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_error_d   = i_bresp[1];
                        rsp_timeout_d = 1'b0;
                    end else if (rsp_valid_q && !i_rsp_ready) begin
                        state_d = DONE;
                    end else begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end
            end
            RA: begin
                if (!arvalid_d) begin
                    state_d  = RR;
                    rready_d = 1'b1;
                end
            end
            RR: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (!timed_out_q) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = i_rdata;
                        rsp_error_d   = i_rresp[1];
                        rsp_timeout_d = 1'b0;
                    end else if (rsp_valid_q && !i_rsp_ready) begin
                        state_d = DONE;
                    end else begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (rsp_hs) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The ready register rises one cycle after reset lifts.
        if (state_q == IDLE && !cmd_ready_q && !rsp_valid_q)
            cmd_ready_d = 1'b1;
    end

    always_ff @(posedge clk or negedge sclrn) begin
        if (!sclrn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            timer_q       <= '0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            timer_q       <= timer_d;
            timed_out_q   <= timed_out_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_error   = rsp_error_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_awvalid     = awvalid_q;
    assign o_awaddr      = addr_q;
    assign o_wvalid      = wvalid_q;
    assign o_wdata       = wdata_q;
    assign o_wstrb       = '1;
    assign o_bready      = bready_q;
    assign o_arvalid     = arvalid_q;
    assign o_araddr      = addr_q;
    assign o_rready      = rready_q;
endmodule
